// File: rtl/fnd_ctrl_pkg.sv
// Shared constants for the FND value controller: display ranges, mode encoding,
// button indices and the auto-repeat state encoding.
package fnd_ctrl_pkg;

   localparam logic [7:0] DEC_MAX  = 8'd99;
   localparam logic [7:0] HEX_MAX  = 8'd255;

   localparam logic       MODE_DEC = 1'b0;
   localparam logic       MODE_HEX = 1'b1;

   localparam int         BTN_UP   = 0;
   localparam int         BTN_DOWN = 1;
   localparam int         BTN_MODE = 2;
   localparam int         BTN_NUM  = 3;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_HOLD   = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   function automatic logic [7:0] mode_max(input logic mode);
      return (mode == MODE_HEX) ? HEX_MAX : DEC_MAX;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, registered one-cycle press pulse.
// The debounced level is exported only when AUTO_REPEAT_EN is defined.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_250_000
) (
   input  logic iCLK,
   input  logic inReset,
   input  logic iBtn,
`ifdef AUTO_REPEAT_EN
   output logic oLevel,
`endif
   output logic oPress
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          prev_q;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronised sample disagrees with the
   // accepted level; any agreeing sample restarts the qualification window.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = level_q & ~prev_q;
   end

   always_ff @(posedge iCLK or negedge inReset) begin
      if (!inReset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= iBtn;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef AUTO_REPEAT_EN
   assign oLevel = level_q;
`endif
   assign oPress = press_q;

endmodule

// File: rtl/fnd_value_ctrl.sv
// Value/mode source for the 2-digit FND: debounced up/down/mode buttons, PS load override,
// range wrap/saturation. Optional hold-to-repeat stepping when AUTO_REPEAT_EN is defined.
module fnd_value_ctrl
   import fnd_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_250_000,
   parameter int REPEAT_DELAY    = 62_500_000,
   parameter int REPEAT_PERIOD   = 12_500_000
) (
   input  logic       iCLK,
   input  logic       inReset,
   input  logic       iBtnUp,
   input  logic       iBtnDown,
   input  logic       iBtnMode,
   input  logic       iLoad,
   input  logic [7:0] iLoadVal,
   output logic [7:0] oHex,
   output logic       oDisplayMode,
   output logic       oChanged
);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("fnd_value_ctrl: timing parameters must be at least 1");
   end

   logic [BTN_NUM-1:0] btn_raw;
   logic [BTN_NUM-1:0] btn_press;
`ifdef AUTO_REPEAT_EN
   logic [BTN_NUM-1:0] btn_lvl;
`endif

   assign btn_raw = {iBtnMode, iBtnDown, iBtnUp};

   for (genvar gi = 0; gi < BTN_NUM; gi++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .iCLK    (iCLK),
         .inReset (inReset),
         .iBtn    (btn_raw[gi]),
`ifdef AUTO_REPEAT_EN
         .oLevel  (btn_lvl[gi]),
`endif
         .oPress  (btn_press[gi])
      );
   end

   logic up_ev, down_ev;

`ifdef AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCW  = $clog2(RMAX + 1);

   rpt_state_e     state_q, state_d;
   logic [RCW-1:0] rcnt_q, rcnt_d;
   logic           dir_up_q, dir_up_d;
   logic           rep_step;
   logic           abort;
   logic           held, other;
   logic [RCW-1:0] rcnt_last;

   // A held mode button counts as an abort so repeat never runs alongside a mode change.
   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      dir_up_d  = dir_up_q;
      rep_step  = 1'b0;
      abort     = iLoad | btn_press[BTN_MODE] | btn_lvl[BTN_MODE];
      held      = dir_up_q ? btn_lvl[BTN_UP]   : btn_lvl[BTN_DOWN];
      other     = dir_up_q ? btn_lvl[BTN_DOWN] : btn_lvl[BTN_UP];
      rcnt_last = (state_q == RPT_HOLD) ? RCW'(REPEAT_DELAY - 1) : RCW'(REPEAT_PERIOD - 1);
      case (state_q)
         RPT_IDLE: begin
            if (!abort && (btn_press[BTN_UP] ^ btn_press[BTN_DOWN]) &&
                !(btn_lvl[BTN_UP] & btn_lvl[BTN_DOWN])) begin
               state_d  = RPT_HOLD;
               rcnt_d   = '0;
               dir_up_d = btn_press[BTN_UP];
            end
         end
         RPT_HOLD, RPT_REPEAT: begin
            if (abort || !held || other) begin
               state_d = RPT_IDLE;
               rcnt_d  = '0;
            end else if (rcnt_q == rcnt_last) begin
               rep_step = 1'b1;
               rcnt_d   = '0;
               state_d  = RPT_REPEAT;
            end else begin
               rcnt_d = rcnt_q + RCW'(1);
            end
         end
         default: begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge inReset) begin
      if (!inReset) begin
         state_q  <= RPT_IDLE;
         rcnt_q   <= '0;
         dir_up_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rcnt_q   <= rcnt_d;
         dir_up_q <= dir_up_d;
      end
   end

   assign up_ev   = btn_press[BTN_UP]   | (rep_step &  dir_up_q);
   assign down_ev = btn_press[BTN_DOWN] | (rep_step & ~dir_up_q);
`else
   assign up_ev   = btn_press[BTN_UP];
   assign down_ev = btn_press[BTN_DOWN];
`endif

   logic [7:0] hex_q, hex_d;
   logic       mode_q, mode_d;
   logic       changed_q, changed_d;
   logic [7:0] cur_max;

   // Decimal mode keeps hex_q <= 99 at all times, so wrap compares need only equality.
   always_comb begin
      hex_d   = hex_q;
      mode_d  = mode_q;
      cur_max = mode_max(mode_q);
      if (iLoad) begin
         hex_d = (mode_q == MODE_DEC && iLoadVal > DEC_MAX) ? DEC_MAX : iLoadVal;
      end else if (btn_press[BTN_MODE]) begin
         mode_d = ~mode_q;
         if (mode_q == MODE_HEX && hex_q > DEC_MAX) begin
            hex_d = DEC_MAX;
         end
      end else if (up_ev && !down_ev) begin
         hex_d = (hex_q == cur_max) ? 8'd0 : hex_q + 8'd1;
      end else if (down_ev && !up_ev) begin
         hex_d = (hex_q == 8'd0) ? cur_max : hex_q - 8'd1;
      end
      changed_d = (hex_d != hex_q) || (mode_d != mode_q);
   end

   always_ff @(posedge iCLK or negedge inReset) begin
      if (!inReset) begin
         hex_q     <= 8'd0;
         mode_q    <= MODE_DEC;
         changed_q <= 1'b0;
      end else begin
         hex_q     <= hex_d;
         mode_q    <= mode_d;
         changed_q <= changed_d;
      end
   end

   assign oHex         = hex_q;
   assign oDisplayMode = mode_q;
   assign oChanged     = changed_q;

endmodule

// File: tb/tb_fnd_value_ctrl.sv
// Directed bench for fnd_value_ctrl with a cycle-by-cycle reference model of the
// debounce/value rules; AUTO_REPEAT_EN selects the repeat expectations.
module tb_fnd_value_ctrl;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 5;

   logic       iCLK = 1'b0;
   logic       inReset = 1'b1;
   logic       iBtnUp = 1'b0, iBtnDown = 1'b0, iBtnMode = 1'b0;
   logic       iLoad = 1'b0;
   logic [7:0] iLoadVal = 8'd0;
   logic [7:0] oHex;
   logic       oDisplayMode;
   logic       oChanged;

   int vectors = 0;
   int miscompares = 0;
   int chg_count = 0;
   logic chk_en = 1'b0;

   fnd_value_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .iCLK         (iCLK),
      .inReset      (inReset),
      .iBtnUp       (iBtnUp),
      .iBtnDown     (iBtnDown),
      .iBtnMode     (iBtnMode),
      .iLoad        (iLoad),
      .iLoadVal     (iLoadVal),
      .oHex         (oHex),
      .oDisplayMode (oDisplayMode),
      .oChanged     (oChanged)
   );

   always #5 iCLK = ~iCLK;

   // Reference model: raw-sample history per button, a level that flips once the
   // last D synchronised samples all disagree with it, events two edges after a rise.
   logic [D:0] rh_up, rh_dn, rh_md;
   logic [2:0] lh_up, lh_dn, lh_md;
   logic [7:0] m_hex;
   logic       m_mode, m_chg;
   logic       ev_up, ev_dn, ev_md;
   logic       m_rep, m_dir_now;
   logic [8:0] nv;

   function automatic logic deb_next(input logic [D:0] h, input logic lvl);
      for (int k = 1; k <= D; k++) begin
         if (h[k] == lvl) return lvl;
      end
      return ~lvl;
   endfunction

   function automatic logic [8:0] next_val(input logic [7:0] hex, input logic mode,
                                          input logic ld, input logic [7:0] lv,
                                          input logic up, input logic dn, input logic mev);
      int   h, mx;
      logic md;
      h  = hex;
      md = mode;
      mx = mode ? 255 : 99;
      if (ld) h = (!mode && lv > 99) ? 99 : int'(lv);
      else if (mev) begin
         md = !mode;
         if (mode && h > 99) h = 99;
      end
      else if (up && !dn) h = (h + 1) % (mx + 1);
      else if (dn && !up) h = (h + mx) % (mx + 1);
      return {md, 8'(h)};
   endfunction

   assign ev_up = lh_up[1] & ~lh_up[2];
   assign ev_dn = lh_dn[1] & ~lh_dn[2];
   assign ev_md = lh_md[1] & ~lh_md[2];

`ifdef AUTO_REPEAT_EN
   logic m_active, m_dir, m_start, m_stop;
   int   t_edge, m_t0;
   always_comb begin
      m_rep   = 1'b0;
      m_stop  = 1'b0;
      m_start = 1'b0;
      if (m_active) begin
         if (iLoad || ev_md || lh_md[0] || !(m_dir ? lh_up[0] : lh_dn[0]) ||
             (m_dir ? lh_dn[0] : lh_up[0]))
            m_stop = 1'b1;
         else if (t_edge - m_t0 >= RD && (t_edge - m_t0 - RD) % RP == 0)
            m_rep = 1'b1;
      end else begin
         m_start = !(iLoad || ev_md || lh_md[0]) && (ev_up ^ ev_dn) && !(lh_up[0] && lh_dn[0]);
      end
   end
   assign m_dir_now = m_dir;

   always @(posedge iCLK or negedge inReset) begin
      if (!inReset) begin
         m_active <= 1'b0;
         m_dir    <= 1'b0;
         m_t0     <= 0;
         t_edge   <= 0;
      end else begin
         t_edge <= t_edge + 1;
         if (m_stop) m_active <= 1'b0;
         else if (m_start) begin
            m_active <= 1'b1;
            m_dir    <= ev_up;
            m_t0     <= t_edge;
         end
      end
   end
`else
   assign m_rep     = 1'b0;
   assign m_dir_now = 1'b0;
`endif

   always_comb begin
      nv = next_val(m_hex, m_mode, iLoad, iLoadVal,
                    ev_up | (m_rep & m_dir_now), ev_dn | (m_rep & ~m_dir_now), ev_md);
   end

   always @(posedge iCLK or negedge inReset) begin
      if (!inReset) begin
         rh_up <= '0; rh_dn <= '0; rh_md <= '0;
         lh_up <= '0; lh_dn <= '0; lh_md <= '0;
         m_hex <= 8'd0; m_mode <= 1'b0; m_chg <= 1'b0;
      end else begin
         rh_up <= {rh_up[D-1:0], iBtnUp};
         rh_dn <= {rh_dn[D-1:0], iBtnDown};
         rh_md <= {rh_md[D-1:0], iBtnMode};
         lh_up <= {lh_up[1:0], deb_next(rh_up, lh_up[0])};
         lh_dn <= {lh_dn[1:0], deb_next(rh_dn, lh_dn[0])};
         lh_md <= {lh_md[1:0], deb_next(rh_md, lh_md[0])};
         {m_mode, m_hex} <= nv;
         m_chg <= (nv != {m_mode, m_hex});
      end
   end

   // Every-cycle compare against the model.
   always @(negedge iCLK) begin
      if (chk_en) begin
         vectors++;
         if (oHex !== m_hex || oDisplayMode !== m_mode || oChanged !== m_chg) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t: got hex=%0d mode=%0b chg=%0b, want hex=%0d mode=%0b chg=%0b",
                     $time, oHex, oDisplayMode, oChanged, m_hex, m_mode, m_chg);
         end
         if (oChanged === 1'b1) chg_count++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end else begin
         $display("check %s = %0d ok", name, act);
      end
   endtask

   task automatic do_load(input logic [7:0] v);
      iLoad = 1'b1; iLoadVal = v;
      cyc(1);
      iLoad = 1'b0;
      cyc(1);
      $display("load 0x%02h -> oHex=%0d mode=%0b", v, oHex, oDisplayMode);
   endtask

   task automatic press(input int b);
      case (b)
         0: iBtnUp = 1'b1;
         1: iBtnDown = 1'b1;
         default: iBtnMode = 1'b1;
      endcase
      cyc(D + 6);
      iBtnUp = 1'b0; iBtnDown = 1'b0; iBtnMode = 1'b0;
      cyc(D + 6);
      $display("press btn%0d -> oHex=%0d mode=%0b", b, oHex, oDisplayMode);
   endtask

   int c0;

   initial begin
      #2 inReset = 1'b0;
      chk_en = 1'b1;
      cyc(2);
      inReset = 1'b1;
      cyc(2);
      check("reset_hex", int'(oHex), 0);
      check("reset_mode", int'(oDisplayMode), 0);
      check("reset_chg", int'(oChanged), 0);

      // 1: glitches then clean hold, exact latency
      iBtnUp = 1'b1; cyc(2); iBtnUp = 1'b0; cyc(2);
      iBtnUp = 1'b1; cyc(2); iBtnUp = 1'b0; cyc(3);
      check("t1_glitch_no_step", int'(oHex), 0);
      c0 = chg_count;
      iBtnUp = 1'b1;
      cyc(D + 3);
      check("t1_before_latency", int'(oHex), 0);
      cyc(1);
      check("t1_at_latency", int'(oHex), 1);
      cyc(4);
      iBtnUp = 1'b0;
      cyc(D + 6);
      check("t1_one_step", int'(oHex), 1);
      check("t1_chg_pulses", chg_count - c0, 1);

      // 2: wrap in both modes
      do_load(8'd99);
      check("t2_load99", int'(oHex), 99);
      press(0);
      check("t2_dec_wrap_up", int'(oHex), 0);
      press(1);
      check("t2_dec_wrap_down", int'(oHex), 99);
      press(2);
      check("t2_mode_hex", int'(oDisplayMode), 1);
      do_load(8'hFF);
      check("t2_loadFF", int'(oHex), 255);
      press(0);
      check("t2_hex_wrap_up", int'(oHex), 0);

      // 3: saturation on mode switch and on load
      do_load(8'hC8);
      check("t3_loadC8", int'(oHex), 200);
      press(2);
      check("t3_mode_dec", int'(oDisplayMode), 0);
      check("t3_sat_mode", int'(oHex), 99);
      do_load(8'd200);
      check("t3_sat_load", int'(oHex), 99);

      // 4: simultaneous up/down; load beats up event
      c0 = chg_count;
      iBtnUp = 1'b1; iBtnDown = 1'b1;
      cyc(D + 6);
      iBtnUp = 1'b0; iBtnDown = 1'b0;
      cyc(D + 6);
      check("t4_updown_hex", int'(oHex), 99);
      check("t4_updown_chg", chg_count - c0, 0);
      iBtnUp = 1'b1;
      cyc(D + 3);
      iLoad = 1'b1; iLoadVal = 8'd42;
      cyc(1);
      iLoad = 1'b0;
      check("t4_load_wins", int'(oHex), 42);
      cyc(3);
      iBtnUp = 1'b0;
      cyc(D + 6);
      check("t4_after", int'(oHex), 42);

      // 5: hold up 50 cycles
      do_load(8'd0);
      iBtnUp = 1'b1;
      cyc(50);
      iBtnUp = 1'b0;
      cyc(D + 10);
`ifdef AUTO_REPEAT_EN
      check("t5_hold50", int'(oHex), 7);
`else
      check("t5_hold50", int'(oHex), 1);
`endif

      // 6: reset mid-hold and mid-debounce
      press(2);
      check("t6_mode_hex", int'(oDisplayMode), 1);
      iBtnUp = 1'b1;
      cyc(D + 6);
      #3 inReset = 1'b0;
      #1;
      check("t6_rst_hex", int'(oHex), 0);
      check("t6_rst_mode", int'(oDisplayMode), 0);
      check("t6_rst_chg", int'(oChanged), 0);
      iBtnUp = 1'b0;
      cyc(2);
      inReset = 1'b1;
      cyc(D + 10);
      check("t6_no_phantom_hold", int'(oHex), 0);
      iBtnUp = 1'b1;
      cyc(2);
      #2 inReset = 1'b0;
      #1;
      check("t6_rst2_hex", int'(oHex), 0);
      iBtnUp = 1'b0;
      cyc(2);
      inReset = 1'b1;
      cyc(D + 10);
      check("t6_no_phantom_deb", int'(oHex), 0);
      press(0);
      check("t6_fresh_press", int'(oHex), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
